prescaled_counter: RTL and testbench
====================================

Name: prescaled_counter

Overview:
- Parametrised successor to the 1 Hz display counter: a free-running prescaler divides `clk` down to a step rate, and each step advances a WIDTH-bit counter.
- Adds enable, up/down direction, synchronous clear and load, an optional BCD mode, and registered tick/wrap pulses.
- Drives the segment-display datapath: in BCD mode each nibble feeds one digit directly.

Parameters:
- WIDTH, 24, counter width in bits; must be a multiple of 4 when BCD=1.
- PERIOD, 100000000, enabled `clk` cycles per count step; legal range is ≥1.
- BCD, 0, 0 = binary count 0..2^WIDTH-1; 1 = each 4-bit nibble counts 0..9 with decimal carry/borrow.

Ports:
- clk  in  1  system clock (100 MHz on board).
- rst  in  1  synchronous active-high reset.
- en  in  1  1 = prescaler runs; 0 = prescaler and count hold.
- up  in  1  1 = count up, 0 = count down; sampled on step cycles.
- clr  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  current count, registered.
- tick  out  1  one-cycle pulse marking a step.
- wrap  out  1  one-cycle pulse when a step wraps count.

Behaviour:
- Internal prescaler `pre` is an unsigned register, ceil(log2(PERIOD)) bits (minimum 1), range 0..PERIOD-1.
- All outputs are registered. Reset values: count=0, tick=0, wrap=0, pre=0.
- Priority per rising edge is rst > clr > load > step > hold.
- rst=1: count, pre, tick and wrap all go to 0.
- clr=1: count=0, pre=0, tick=0, wrap=0. This happens regardless of en.
- load=1: pre=0, tick=0, wrap=0, and count=load_val, regardless of en.
  - In BCD mode, any nibble >9 loads as 9.
- Step cycle: en=1 and pre==PERIOD-1, with no clr/load.
  - pre=0 and tick=1.
  - count=next(count,up).
  - wrap=1 if that step wrapped, else 0.
- en=1, pre<PERIOD-1: pre=pre+1, tick=0, wrap=0, count holds.
- en=0: pre and count hold, tick=0, wrap=0. Deasserting en mid-period resumes from the same pre value; no phase is lost.
- PERIOD=1: every enabled cycle is a step cycle, so tick stays high continuously while en=1.
- Latency:
  - From reset release with en=1, the first tick and first count change occur on edge PERIOD.
  - Consecutive steps occur every PERIOD enabled cycles.
  - count and tick update on the same edge.
- Binary next:
  - Up: count+1 mod 2^WIDTH; wrap when count was all ones.
  - Down: count-1 mod 2^WIDTH; wrap when count was 0.
- BCD next: nibble-wise decimal arithmetic.
  - Up: digit 9 becomes 0 with carry into the next nibble.
  - Down: digit 0 becomes 9 with borrow from the next nibble.
  - Up from all nines gives all zeros with wrap=1.
  - Down from all zeros gives all nines with wrap=1.
  - Nibbles >9 are unreachable except via the load saturation rule above.
- up changing mid-period takes effect at the next step only.
- clr or load coinciding with a would-be step cancels that step: no tick, no wrap, and the prescaler restarts from 0.
- rst asserted mid-period discards prescaler phase entirely.

Test Plan:
- Reset/period (WIDTH=8, PERIOD=4, BCD=0): rst 2 cycles, then en=1, up=1 → count steps 0→1→2 on edges 4, 8; tick high exactly on those edges; wrap=0.
- Binary wrap both ways (WIDTH=8, PERIOD=1):
  - Load 8'hFE, run up → FF, then 00 with wrap=1 on the 00 edge only.
  - Load 8'h01, run down → 00, then FF with wrap=1 on the FF edge.
- BCD carry/borrow (WIDTH=12, PERIOD=2, BCD=1):
  - Load 12'h099, step up → 12'h100.
  - Load 12'h999, step up → 12'h000 with wrap=1.
  - Down from 12'h100 → 12'h099.
  - load_val 12'hFA3 → count 12'h993.
- Enable pause (PERIOD=4): en=1 for 2 cycles, en=0 for 5 cycles, en=1 → first tick after exactly 2 further enabled cycles; count unchanged while en=0.
- Priority collisions:
  - load asserted on a step cycle → count=load_val, tick=0, next tick PERIOD cycles later.
  - clr and load together → count=0.
  - rst with clr/load → reset values.
- Mid-period reset (PERIOD=10): rst after 7 enabled cycles → count=0; next tick exactly 10 enabled cycles after rst deasserts.

Source files
------------

// File: rtl/prescaled_counter.sv
// Prescaled step counter: a free-running prescaler paces a binary or BCD
// up/down counter, with registered tick and wrap pulses for the display path.
module prescaled_counter #(
    parameter int WIDTH  = 24,
    parameter int PERIOD = 100000000,
    parameter bit BCD    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap
);

    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PERIOD - 1);

    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_wrap;

    logic             w_step;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    logic             w_wrap;

    assign w_step = en && (r_pre == PRE_LAST);

    generate
        if (BCD) begin : g_bcd
            localparam int ND = WIDTH / 4;

            // Ripple a decimal carry/borrow from the least significant digit.
            always_comb begin
                logic       c;
                logic [3:0] d;
                w_next = r_count;
                c      = 1'b1;
                d      = 4'd0;
                for (int i = 0; i < ND; i++) begin
                    d = r_count[i*4 +: 4];
                    if (c) begin
                        if (up) begin
                            if (d >= 4'd9) begin
                                d = 4'd0;
                            end else begin
                                d = d + 4'd1;
                                c = 1'b0;
                            end
                        end else begin
                            if (d == 4'd0) begin
                                d = 4'd9;
                            end else begin
                                d = d - 4'd1;
                                c = 1'b0;
                            end
                        end
                    end
                    w_next[i*4 +: 4] = d;
                end
                w_wrap = c;
            end

            // Out-of-range digits saturate so the counter stays decimal.
            always_comb begin
                w_load = load_val;
                for (int i = 0; i < ND; i++) begin
                    if (load_val[i*4 +: 4] > 4'd9) begin
                        w_load[i*4 +: 4] = 4'd9;
                    end
                end
            end
        end else begin : g_bin
            always_comb begin
                w_next = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
                w_wrap = up ? (&r_count) : (~|r_count);
                w_load = load_val;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (clr) begin
            r_pre   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_pre   <= '0;
            r_count <= w_load;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_step) begin
            r_pre   <= '0;
            r_count <= w_next;
            r_tick  <= 1'b1;
            r_wrap  <= w_wrap;
        end else if (en) begin
            r_pre   <= r_pre + PW'(1);
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter: four configurations share one set of
// control inputs; each vector names the instance whose outputs it checks.
module tb_prescaled_counter;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        up   = 1'b1;
    logic        clr  = 1'b0;
    logic        load = 1'b0;
    logic [11:0] lv   = 12'h000;

    logic [7:0]  ca, cb, cd;
    logic [11:0] cc;
    logic        ta, tb_, tc, td;
    logic        wa, wb, wc, wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // A: binary P=4, B: binary P=1, C: BCD P=2, D: binary P=10
    prescaled_counter #(.WIDTH(8), .PERIOD(4), .BCD(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(ca), .tick(ta), .wrap(wa)
    );
    prescaled_counter #(.WIDTH(8), .PERIOD(1), .BCD(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cb), .tick(tb_), .wrap(wb)
    );
    prescaled_counter #(.WIDTH(12), .PERIOD(2), .BCD(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv), .count(cc), .tick(tc), .wrap(wc)
    );
    prescaled_counter #(.WIDTH(8), .PERIOD(10), .BCD(1'b0)) u_d (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cd), .tick(td), .wrap(wd)
    );

    typedef struct {
        int          sel;
        logic        rst;
        logic        en;
        logic        up;
        logic        clr;
        logic        load;
        logic [11:0] lv;
        logic [11:0] ec;
        logic        et;
        logic        ew;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input int s, input logic r, input logic e,
                     input logic u, input logic c, input logic l,
                     input logic [11:0] val, input logic [11:0] ec,
                     input logic et, input logic ew);
        vec_t x;
        x.sel = s; x.rst = r; x.en = e; x.up = u; x.clr = c; x.load = l;
        x.lv = val; x.ec = ec; x.et = et; x.ew = ew;
        tbl.push_back(x);
    endtask

    task automatic sample(input int s, output logic [11:0] c,
                          output logic t, output logic w);
        case (s)
            0: begin c = {4'h0, ca}; t = ta;  w = wa; end
            1: begin c = {4'h0, cb}; t = tb_; w = wb; end
            2: begin c = cc;         t = tc;  w = wc; end
            default: begin c = {4'h0, cd}; t = td; w = wd; end
        endcase
    endtask

    task automatic chk(input string nm, input int idx, input int s,
                       input logic [11:0] ec, input logic et,
                       input logic ew);
        logic [11:0] c;
        logic        t;
        logic        w;
        sample(s, c, t, w);
        checks++;
        if (c !== ec || t !== et || w !== ew) begin
            failures++;
            $display("FAIL %s #%0d inst%0d: count=%h tick=%b wrap=%b, expected count=%h tick=%b wrap=%b",
                     nm, idx, s, c, t, w, ec, et, ew);
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic u,
                       input logic c, input logic l, input logic [11:0] val);
        rst = r; en = e; up = u; clr = c; load = l; lv = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and period on A
        v(0, 1,0,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 1,0,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h001, 1, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h001, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h001, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h001, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h002, 1, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h002, 0, 0);
        // Binary wrap both ways on B (tick stays high)
        v(1, 0,1,1,0,1, 12'h0FE, 12'h0FE, 0, 0);
        v(1, 0,1,1,0,0, 12'h000, 12'h0FF, 1, 0);
        v(1, 0,1,1,0,0, 12'h000, 12'h000, 1, 1);
        v(1, 0,1,1,0,0, 12'h000, 12'h001, 1, 0);
        v(1, 0,1,0,0,1, 12'h001, 12'h001, 0, 0);
        v(1, 0,1,0,0,0, 12'h000, 12'h000, 1, 0);
        v(1, 0,1,0,0,0, 12'h000, 12'h0FF, 1, 1);
        v(1, 0,1,0,0,0, 12'h000, 12'h0FE, 1, 0);
        // BCD carry/borrow/saturation on C
        v(2, 0,1,1,0,1, 12'h099, 12'h099, 0, 0);
        v(2, 0,1,1,0,0, 12'h000, 12'h099, 0, 0);
        v(2, 0,1,1,0,0, 12'h000, 12'h100, 1, 0);
        v(2, 0,1,1,0,1, 12'h999, 12'h999, 0, 0);
        v(2, 0,1,1,0,0, 12'h000, 12'h999, 0, 0);
        v(2, 0,1,1,0,0, 12'h000, 12'h000, 1, 1);
        v(2, 0,1,0,0,1, 12'h100, 12'h100, 0, 0);
        v(2, 0,1,0,0,0, 12'h000, 12'h100, 0, 0);
        v(2, 0,1,0,0,0, 12'h000, 12'h099, 1, 0);
        v(2, 0,1,0,0,1, 12'hFA3, 12'h993, 0, 0);
        v(2, 0,1,0,0,0, 12'h000, 12'h993, 0, 0);
        v(2, 0,1,0,0,0, 12'h000, 12'h992, 1, 0);
        v(2, 0,1,0,0,1, 12'h000, 12'h000, 0, 0);
        v(2, 0,1,0,0,0, 12'h000, 12'h000, 0, 0);
        v(2, 0,1,0,0,0, 12'h000, 12'h999, 1, 1);
        // Enable pause on A
        v(0, 1,0,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        for (int i = 0; i < 5; i++)
            v(0, 0,0,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h001, 1, 0);
        // Priority collisions on A
        v(0, 1,0,1,0,0, 12'h000, 12'h000, 0, 0);
        for (int i = 0; i < 3; i++)
            v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,1, 12'h055, 12'h055, 0, 0);
        for (int i = 0; i < 3; i++)
            v(0, 0,1,1,0,0, 12'h000, 12'h055, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h056, 1, 0);
        v(0, 0,1,1,1,1, 12'h0AA, 12'h000, 0, 0);
        v(0, 0,1,1,0,1, 12'h033, 12'h033, 0, 0);
        v(0, 1,1,1,1,1, 12'h077, 12'h000, 0, 0);
        for (int i = 0; i < 3; i++)
            v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,1,0, 12'h000, 12'h000, 0, 0);
        for (int i = 0; i < 3; i++)
            v(0, 0,1,1,0,0, 12'h000, 12'h000, 0, 0);
        v(0, 0,1,1,0,0, 12'h000, 12'h001, 1, 0);

        // Initial reset leaves every configuration at zero
        cyc(1, 0, 1, 0, 0, 12'h000);
        for (int s = 0; s < 4; s++)
            chk("reset", 0, s, 12'h000, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].clr,
                tbl[i].load, tbl[i].lv);
            chk("vec", i, tbl[i].sel, tbl[i].ec, tbl[i].et, tbl[i].ew);
        end

        // Mid-period reset on D discards prescaler phase
        cyc(1, 0, 1, 0, 0, 12'h000);
        chk("midrst_init", 0, 3, 12'h000, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cyc(0, 1, 1, 0, 0, 12'h000);
            chk("midrst_pre", i, 3, 12'h000, 1'b0, 1'b0);
        end
        cyc(1, 1, 1, 0, 0, 12'h000);
        chk("midrst_rst", 0, 3, 12'h000, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 1, 0, 0, 12'h000);
            if (i == 10)
                chk("midrst_step", i, 3, 12'h001, 1'b1, 1'b0);
            else
                chk("midrst_wait", i, 3, 12'h000, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
